// File: rtl/riscv_mem_arb_pkg.sv
// Shared types and message widths for the instruction/data memory arbiter.
// Optional statistics counters are enabled with RISCV_MEM_ARB_STATS_EN.
package riscv_mem_arb_pkg;

   localparam int MEM_TYPE_SZ = 1;
   localparam int MEM_ADDR_SZ = 32;
   localparam int MEM_LEN_SZ  = 2;
   localparam int MEM_DATA_SZ = 32;

   localparam int REQ_SZ  = MEM_TYPE_SZ + MEM_ADDR_SZ + MEM_LEN_SZ + MEM_DATA_SZ;
   localparam int RESP_SZ = MEM_TYPE_SZ + MEM_LEN_SZ + MEM_DATA_SZ;

   typedef logic [0:0] port_id_t;

   localparam port_id_t PORT_IMEM = 1'b0;
   localparam port_id_t PORT_DMEM = 1'b1;

   function automatic port_id_t otherPort(input port_id_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/riscv_mem_arb_route_fifo.sv
// Routing FIFO: records which core port issued each outstanding memory request
// so that in-order responses can be steered back to the right port.
module riscv_mem_arb_route_fifo
   import riscv_mem_arb_pkg::*;
#(
   parameter int NUM_OUTSTANDING = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  port_id_t id_in,
   output port_id_t head,
   output logic     full,
   output logic     empty
);

   localparam int PW = $clog2(NUM_OUTSTANDING);
   localparam int CW = PW + 1;

   logic [NUM_OUTSTANDING-1:0] r_mem;
   logic [PW-1:0]              r_wr_ptr;
   logic [PW-1:0]              r_rd_ptr;
   logic [CW-1:0]              r_count;

   logic w_push;
   logic w_pop;

   assign full    = (r_count == CW'(NUM_OUTSTANDING));
   assign empty   = (r_count == '0);
   assign w_push  = push & ~full;
   assign w_pop   = pop & ~empty;
   assign head    = r_mem[r_rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= id_in;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_core_mem_arb.sv
// Merges the core's instruction and data memory ports onto one memory port with
// round-robin grants and FIFO-tracked response routing. Define
// RISCV_MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module riscv_core_mem_arb
   import riscv_mem_arb_pkg::*;
#(
   parameter int NUM_OUTSTANDING = 4,
   parameter int REQ_SZ          = riscv_mem_arb_pkg::REQ_SZ,
   parameter int RESP_SZ         = riscv_mem_arb_pkg::RESP_SZ
) (
   input  logic               clk,
   input  logic               reset,

   input  logic [REQ_SZ-1:0]  imemreq_msg,
   input  logic               imemreq_val,
   output logic               imemreq_rdy,
   output logic [RESP_SZ-1:0] imemresp_msg,
   output logic               imemresp_val,

   input  logic [REQ_SZ-1:0]  dmemreq_msg,
   input  logic               dmemreq_val,
   output logic               dmemreq_rdy,
   output logic [RESP_SZ-1:0] dmemresp_msg,
   output logic               dmemresp_val,

   output logic [REQ_SZ-1:0]  memreq_msg,
   output logic               memreq_val,
   input  logic               memreq_rdy,
   input  logic [RESP_SZ-1:0] memresp_msg,
   input  logic               memresp_val,

   output logic               err_orphan_resp
`ifdef RISCV_MEM_ARB_STATS_EN
   ,
   output logic [31:0]        stat_imem_grants,
   output logic [31:0]        stat_dmem_grants,
   output logic [31:0]        stat_conflicts
`endif
);

   port_id_t r_prio;
   logic     r_err_orphan;

   logic     w_full;
   logic     w_empty;
   port_id_t w_head;
   logic     w_grant_imem;
   logic     w_grant_dmem;
   port_id_t w_grant_id;
   logic     w_fire;
   logic     w_pop;

   // With a single requester it wins outright; on contention the pointer decides.
   assign w_grant_imem = imemreq_val & (~dmemreq_val | (r_prio == PORT_IMEM));
   assign w_grant_dmem = dmemreq_val & (~imemreq_val | (r_prio == PORT_DMEM));
   assign w_grant_id   = w_grant_dmem ? PORT_DMEM : PORT_IMEM;

   // Gating with reset keeps every handshake output low while reset is held.
   assign memreq_val  = reset & (imemreq_val | dmemreq_val) & ~w_full;
   assign memreq_msg  = w_grant_dmem ? dmemreq_msg : imemreq_msg;
   assign imemreq_rdy = reset & memreq_rdy & ~w_full & w_grant_imem;
   assign dmemreq_rdy = reset & memreq_rdy & ~w_full & w_grant_dmem;
   assign w_fire      = memreq_val & memreq_rdy;

   assign w_pop        = reset & memresp_val & ~w_empty;
   assign imemresp_val = w_pop & (w_head == PORT_IMEM);
   assign dmemresp_val = w_pop & (w_head == PORT_DMEM);
   assign imemresp_msg = memresp_msg;
   assign dmemresp_msg = memresp_msg;

   assign err_orphan_resp = r_err_orphan;

   riscv_mem_arb_route_fifo #(
      .NUM_OUTSTANDING (NUM_OUTSTANDING)
   ) u_route_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_fire),
      .pop   (w_pop),
      .id_in (w_grant_id),
      .head  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prio       <= PORT_IMEM;
         r_err_orphan <= 1'b0;
      end else begin
         if (w_fire) begin
            r_prio <= otherPort(w_grant_id);
         end
         if (memresp_val & w_empty) begin
            r_err_orphan <= 1'b1;
         end
      end
   end

`ifdef RISCV_MEM_ARB_STATS_EN
   logic [31:0] r_stat_imem;
   logic [31:0] r_stat_dmem;
   logic [31:0] r_stat_conf;

   // All counters saturate instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_imem <= '0;
         r_stat_dmem <= '0;
         r_stat_conf <= '0;
      end else begin
         if (w_fire & w_grant_imem & (r_stat_imem != '1)) begin
            r_stat_imem <= r_stat_imem + 32'd1;
         end
         if (w_fire & w_grant_dmem & (r_stat_dmem != '1)) begin
            r_stat_dmem <= r_stat_dmem + 32'd1;
         end
         if (w_fire & imemreq_val & dmemreq_val & (r_stat_conf != '1)) begin
            r_stat_conf <= r_stat_conf + 32'd1;
         end
      end
   end

   assign stat_imem_grants = r_stat_imem;
   assign stat_dmem_grants = r_stat_dmem;
   assign stat_conflicts   = r_stat_conf;
`endif

endmodule

// File: tb/tb_riscv_core_mem_arb.sv
// Self-checking bench for riscv_core_mem_arb: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_riscv_core_mem_arb;
   import riscv_mem_arb_pkg::*;

   localparam int N = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [REQ_SZ-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
   logic               imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
   logic [RESP_SZ-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
   logic               imemresp_val, dmemresp_val;
   logic               memreq_val, memreq_rdy, memresp_val;
   logic               err_orphan_resp;
`ifdef RISCV_MEM_ARB_STATS_EN
   logic [31:0]        stat_imem_grants, stat_dmem_grants, stat_conflicts;
`endif

   always #5 clk = ~clk;

   riscv_core_mem_arb #(
      .NUM_OUTSTANDING (N)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imemreq_msg     (imemreq_msg),
      .imemreq_val     (imemreq_val),
      .imemreq_rdy     (imemreq_rdy),
      .imemresp_msg    (imemresp_msg),
      .imemresp_val    (imemresp_val),
      .dmemreq_msg     (dmemreq_msg),
      .dmemreq_val     (dmemreq_val),
      .dmemreq_rdy     (dmemreq_rdy),
      .dmemresp_msg    (dmemresp_msg),
      .dmemresp_val    (dmemresp_val),
      .memreq_msg      (memreq_msg),
      .memreq_val      (memreq_val),
      .memreq_rdy      (memreq_rdy),
      .memresp_msg     (memresp_msg),
      .memresp_val     (memresp_val),
      .err_orphan_resp (err_orphan_resp)
`ifdef RISCV_MEM_ARB_STATS_EN
      ,
      .stat_imem_grants (stat_imem_grants),
      .stat_dmem_grants (stat_dmem_grants),
      .stat_conflicts   (stat_conflicts)
`endif
   );

   // Reference model: outstanding port ids, round-robin preference, sticky error.
   int          mQ[$];
   int          mPrio;
   bit          mErr;
   logic [31:0] mStatI, mStatD, mStatC;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      bit iv, dv, rdy, mv;
      bit eMval, eIrdy, eDrdy, eIrsp, eDrsp, eErr;
   } vec_t;

   vec_t vecs[18];

   task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [REQ_SZ-1:0] randReq();
      return {1'($urandom), 32'($urandom), 2'($urandom), 32'($urandom)};
   endfunction

   task automatic clearModel();
      mQ.delete();
      mPrio  = 0;
      mErr   = 1'b0;
      mStatI = '0;
      mStatD = '0;
      mStatC = '0;
   endtask

   task automatic checkStatsZero();
`ifdef RISCV_MEM_ARB_STATS_EN
      checkOutput("stat_imem_zero", 67'(stat_imem_grants), 67'd0);
      checkOutput("stat_dmem_zero", 67'(stat_dmem_grants), 67'd0);
      checkOutput("stat_conf_zero", 67'(stat_conflicts), 67'd0);
`endif
   endtask

   // Drives one cycle's inputs, checks the DUT against the model mid-cycle and
   // advances the model; the caller steps to the next negedge.
   task automatic applyStimulus(input bit iv, input bit dv, input bit rdy, input bit mv,
                                input logic [REQ_SZ-1:0] imsg, input logic [REQ_SZ-1:0] dmsg,
                                input logic [31:0] rdata);
      bit full, empty, eMval, pop, fire;
      int g;
      imemreq_val = iv;
      dmemreq_val = dv;
      imemreq_msg = imsg;
      dmemreq_msg = dmsg;
      memreq_rdy  = rdy;
      memresp_val = mv;
      memresp_msg = {1'b0, 2'b10, rdata};
      #1;
      full  = (mQ.size() == N);
      empty = (mQ.size() == 0);
      g     = (iv && dv) ? mPrio : (dv ? 1 : 0);
      eMval = (iv || dv) && !full;
      pop   = mv && !empty;
      fire  = eMval && rdy;
      checkOutput("memreq_val", 67'(memreq_val), 67'(eMval));
      checkOutput("imemreq_rdy", 67'(imemreq_rdy), 67'(fire && g == 0));
      checkOutput("dmemreq_rdy", 67'(dmemreq_rdy), 67'(fire && g == 1));
      checkOutput("imemresp_val", 67'(imemresp_val), 67'(pop && mQ[0] == 0));
      checkOutput("dmemresp_val", 67'(dmemresp_val), 67'(pop && mQ[0] == 1));
      checkOutput("err_orphan_resp", 67'(err_orphan_resp), 67'(mErr));
      if (eMval) checkOutput("memreq_msg", 67'(memreq_msg), 67'(g == 1 ? dmsg : imsg));
      if (pop && mQ[0] == 0) checkOutput("imemresp_msg", 67'(imemresp_msg), 67'({1'b0, 2'b10, rdata}));
      if (pop && mQ[0] == 1) checkOutput("dmemresp_msg", 67'(dmemresp_msg), 67'({1'b0, 2'b10, rdata}));
`ifdef RISCV_MEM_ARB_STATS_EN
      checkOutput("stat_imem_grants", 67'(stat_imem_grants), 67'(mStatI));
      checkOutput("stat_dmem_grants", 67'(stat_dmem_grants), 67'(mStatD));
      checkOutput("stat_conflicts", 67'(stat_conflicts), 67'(mStatC));
`endif
      if (pop) void'(mQ.pop_front());
      if (mv && empty) mErr = 1'b1;
      if (fire) begin
         mQ.push_back(g);
         mPrio = (g == 0) ? 1 : 0;
         if (g == 0 && mStatI != 32'hFFFFFFFF) mStatI++;
         if (g == 1 && mStatD != 32'hFFFFFFFF) mStatD++;
         if (iv && dv && mStatC != 32'hFFFFFFFF) mStatC++;
      end
   endtask

   // Holds reset for one cycle with every valid driven high, then releases it.
   task automatic applyReset();
      reset       = 1'b0;
      imemreq_val = 1'b1;
      dmemreq_val = 1'b1;
      memreq_rdy  = 1'b1;
      memresp_val = 1'b1;
      #1;
      checkOutput("rst_memreq_val", 67'(memreq_val), 67'd0);
      checkOutput("rst_imemreq_rdy", 67'(imemreq_rdy), 67'd0);
      checkOutput("rst_dmemreq_rdy", 67'(dmemreq_rdy), 67'd0);
      checkOutput("rst_imemresp_val", 67'(imemresp_val), 67'd0);
      checkOutput("rst_dmemresp_val", 67'(dmemresp_val), 67'd0);
      checkOutput("rst_err_orphan", 67'(err_orphan_resp), 67'd0);
      clearModel();
      checkStatsZero();
      @(negedge clk);
      reset       = 1'b1;
      imemreq_val = 1'b0;
      dmemreq_val = 1'b0;
      memreq_rdy  = 1'b0;
      memresp_val = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [REQ_SZ-1:0] req100;
      bit expI[4];
      bit expD[4];

      reset       = 1'b0;
      imemreq_val = 1'b0;
      dmemreq_val = 1'b0;
      memreq_rdy  = 1'b0;
      memresp_val = 1'b0;
      imemreq_msg = '0;
      dmemreq_msg = '0;
      memresp_msg = '0;
      clearModel();

      //         iv dv rdy mv | mval irdy drdy irsp drsp err
      vecs[0]  = '{1, 0, 1, 0,   1, 1, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 1,   0, 0, 0, 1, 0, 0};
      vecs[2]  = '{1, 1, 1, 0,   1, 0, 1, 0, 0, 0};
      vecs[3]  = '{1, 1, 1, 0,   1, 1, 0, 0, 0, 0};
      vecs[4]  = '{1, 1, 0, 1,   1, 0, 0, 0, 1, 0};
      vecs[5]  = '{1, 1, 1, 1,   1, 0, 1, 1, 0, 0};
      vecs[6]  = '{0, 1, 1, 0,   1, 0, 1, 0, 0, 0};
      vecs[7]  = '{0, 1, 1, 0,   1, 0, 1, 0, 0, 0};
      vecs[8]  = '{0, 1, 1, 0,   1, 0, 1, 0, 0, 0};
      vecs[9]  = '{0, 1, 1, 0,   0, 0, 0, 0, 0, 0};
      vecs[10] = '{0, 1, 1, 1,   0, 0, 0, 0, 1, 0};
      vecs[11] = '{0, 1, 1, 0,   1, 0, 1, 0, 0, 0};
      vecs[12] = '{1, 0, 1, 1,   0, 0, 0, 0, 1, 0};
      vecs[13] = '{0, 0, 0, 1,   0, 0, 0, 0, 1, 0};
      vecs[14] = '{0, 0, 0, 1,   0, 0, 0, 0, 1, 0};
      vecs[15] = '{0, 0, 0, 1,   0, 0, 0, 0, 1, 0};
      vecs[16] = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 0};
      vecs[17] = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 1};

      @(negedge clk);
      applyReset();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].iv, vecs[i].dv, vecs[i].rdy, vecs[i].mv,
                       randReq(), randReq(), $urandom);
         checkOutput($sformatf("vec%0d_memreq_val", i), 67'(memreq_val), 67'(vecs[i].eMval));
         checkOutput($sformatf("vec%0d_imemreq_rdy", i), 67'(imemreq_rdy), 67'(vecs[i].eIrdy));
         checkOutput($sformatf("vec%0d_dmemreq_rdy", i), 67'(dmemreq_rdy), 67'(vecs[i].eDrdy));
         checkOutput($sformatf("vec%0d_imemresp_val", i), 67'(imemresp_val), 67'(vecs[i].eIrsp));
         checkOutput($sformatf("vec%0d_dmemresp_val", i), 67'(dmemresp_val), 67'(vecs[i].eDrsp));
         checkOutput($sformatf("vec%0d_err", i), 67'(err_orphan_resp), 67'(vecs[i].eErr));
         @(negedge clk);
      end

      // Single instruction read of 0x100 answered two cycles later.
      applyReset();
      req100 = {1'b0, 32'h0000_0100, 2'b00, 32'h0};
      applyStimulus(1, 0, 1, 0, req100, randReq(), 32'h0);
      checkOutput("single_memreq_msg", 67'(memreq_msg), 67'(req100));
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, randReq(), randReq(), 32'h0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, randReq(), randReq(), 32'hDEADBEEF);
      checkOutput("single_imemresp_val", 67'(imemresp_val), 67'd1);
      checkOutput("single_imemresp_data", 67'(imemresp_msg[31:0]), 67'(32'hDEADBEEF));
      checkOutput("single_dmemresp_val", 67'(dmemresp_val), 67'd0);
      @(negedge clk);

      // Contention: grants alternate, responses 1..4 follow the same order.
      applyReset();
      expI = '{1, 0, 1, 0};
      expD = '{0, 1, 0, 1};
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 1, 1, 0, randReq(), randReq(), 32'h0);
         checkOutput($sformatf("contend%0d_irdy", k), 67'(imemreq_rdy), 67'(expI[k]));
         checkOutput($sformatf("contend%0d_drdy", k), 67'(dmemreq_rdy), 67'(expD[k]));
         @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 1, randReq(), randReq(), 32'(k + 1));
         checkOutput($sformatf("route%0d_irsp", k), 67'(imemresp_val), 67'(expI[k]));
         checkOutput($sformatf("route%0d_drsp", k), 67'(dmemresp_val), 67'(expD[k]));
         @(negedge clk);
      end

      // Backpressure: no handshake and no pointer movement until memory is ready.
      applyReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 1, 0, 0, randReq(), randReq(), 32'h0);
         checkOutput("bp_irdy", 67'(imemreq_rdy), 67'd0);
         checkOutput("bp_drdy", 67'(dmemreq_rdy), 67'd0);
         @(negedge clk);
      end
      applyStimulus(1, 1, 1, 0, randReq(), randReq(), 32'h0);
      checkOutput("bp_first_grant_imem", 67'(imemreq_rdy), 67'd1);
      checkOutput("bp_first_grant_dmem", 67'(dmemreq_rdy), 67'd0);
      @(negedge clk);

      // Orphan response: sticky until the next reset.
      applyReset();
      applyStimulus(0, 0, 0, 1, randReq(), randReq(), 32'h1234);
      checkOutput("orphan_irsp", 67'(imemresp_val), 67'd0);
      checkOutput("orphan_drsp", 67'(dmemresp_val), 67'd0);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, 0, 0, randReq(), randReq(), 32'h0);
         checkOutput("orphan_sticky", 67'(err_orphan_resp), 67'd1);
         @(negedge clk);
      end
      applyReset();

      // Async reset between edges with two requests in flight.
      applyStimulus(1, 0, 1, 0, randReq(), randReq(), 32'h0);
      @(negedge clk);
      applyStimulus(0, 1, 1, 0, randReq(), randReq(), 32'h0);
      @(negedge clk);
      #2;
      imemreq_val = 1'b1;
      dmemreq_val = 1'b1;
      memreq_rdy  = 1'b1;
      memresp_val = 1'b1;
      reset       = 1'b0;
      #1;
      checkOutput("async_memreq_val", 67'(memreq_val), 67'd0);
      checkOutput("async_irdy", 67'(imemreq_rdy), 67'd0);
      checkOutput("async_drdy", 67'(dmemreq_rdy), 67'd0);
      checkOutput("async_irsp", 67'(imemresp_val), 67'd0);
      checkOutput("async_drsp", 67'(dmemresp_val), 67'd0);
      clearModel();
      checkStatsZero();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 1, randReq(), randReq(), 32'h55);
      checkOutput("late_resp_dropped", 67'(imemresp_val | dmemresp_val), 67'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, randReq(), randReq(), 32'h0);
      checkOutput("late_resp_orphan", 67'(err_orphan_resp), 67'd1);
      @(negedge clk);

      // Random traffic against the model.
      applyReset();
      for (int k = 0; k < 400; k++) begin
         bit iv, dv, rdy, mv;
         iv  = 1'($urandom_range(0, 1));
         dv  = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 3) != 0);
         mv  = (mQ.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
         applyStimulus(iv, dv, rdy, mv, randReq(), randReq(), $urandom);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
